// File: rtl/kf_au_defs.sv
// Shared definitions for the Kalman-core arithmetic unit and the arbiter that shares it.
// Values are S9.14 sign-magnitude: bit W-1 is the sign, the low W-1 bits the magnitude.
package kf_au_defs;

   localparam int W    = 24;
   localparam int FRAC = 14;

   // au op_sel codes
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // au mul_y_sel codes
   localparam logic [1:0] YSEL_S     = 2'b00;
   localparam logic [1:0] YSEL_IMM   = 2'b01;
   localparam logic [1:0] YSEL_RECIP = 2'b10;
   localparam logic [1:0] YSEL_ONE   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } arb_state_e;

   // Width of an index into n items; never zero so a 1-entry index is still a legal vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, with wrap.
// Shared by every arbiter that hands out a single resource among N clients.
module rr_pick
   import kf_au_defs::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   int pos;

   // NOTE: every output gets a default before the search so no path can leave one unassigned (no latch).
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!found && valid[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/au_arbiter.sv
// Round-robin arbiter sharing one multi-cycle arithmetic unit among NREQ requesters,
// with a watchdog that aborts an operation whose au_done never arrives.
module au_arbiter
   import kf_au_defs::*;
#(
   parameter int W       = 24,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*W-1:0]   req_R,
   input  logic [NREQ*W-1:0]   req_S,
   input  logic [NREQ*W-1:0]   req_Iimm,
   input  logic [NREQ*2-1:0]   req_op,
   input  logic [NREQ*2-1:0]   req_ysel,
   output logic [NREQ-1:0]     resp_valid,
   output logic                resp_err,
   output logic [W-1:0]        resp_result,
   output logic                au_start,
   output logic [W-1:0]        au_R,
   output logic [W-1:0]        au_S,
   output logic [W-1:0]        au_Iimm,
   output logic [1:0]          au_op_sel,
   output logic [1:0]          au_mul_y_sel,
   input  logic [W-1:0]        au_result,
   input  logic                au_done,
   input  logic                au_busy,
   output logic                arb_busy
);

   localparam int              IW     = idx_width(NREQ);
   localparam int              TW     = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0]   LAST   = IW'(NREQ - 1);
   localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

   arb_state_e        state, state_nxt;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     g_idx;
   logic [TW-1:0]     timer;
   logic [NREQ-1:0]   pick_grant;
   logic [IW-1:0]     pick_idx;
   logic              pick_found;
   logic              accept;
   logic              finish_ok;
   logic              finish_err;
   logic [NREQ-1:0]   g_onehot;

   rr_pick #(.N(NREQ)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign g_onehot = NREQ'(1) << g_idx;
   assign arb_busy = (state != ST_IDLE);

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      au_start   = 1'b0;
      accept     = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      unique case (state)
         ST_IDLE: begin
            // Gated by rst_n so no acceptance is advertised while reset is held.
            if (pick_found && rst_n) begin
               req_ready = pick_grant;
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!au_busy) begin
               au_start  = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A done arriving on the last watchdog cycle still counts as success.
            if (au_done) begin
               finish_ok = 1'b1;
               state_nxt = ST_IDLE;
            end else if (timer == T_LAST) begin
               finish_err = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the operand registers are reset too; they are plain flops, and the outputs must read 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         g_idx        <= '0;
         timer        <= '0;
         au_R         <= '0;
         au_S         <= '0;
         au_Iimm      <= '0;
         au_op_sel    <= '0;
         au_mul_y_sel <= '0;
         resp_valid   <= '0;
         resp_err     <= 1'b0;
         resp_result  <= '0;
      end else begin
         resp_valid <= '0;
         if (accept) begin
            g_idx        <= pick_idx;
            rr_ptr       <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
            au_R         <= req_R[pick_idx*W +: W];
            au_S         <= req_S[pick_idx*W +: W];
            au_Iimm      <= req_Iimm[pick_idx*W +: W];
            au_op_sel    <= req_op[pick_idx*2 +: 2];
            au_mul_y_sel <= req_ysel[pick_idx*2 +: 2];
         end
         if (au_start)              timer <= '0;
         else if (state == ST_WAIT) timer <= timer + 1'b1;
         if (finish_ok) begin
            resp_result <= au_result;
            resp_err    <= 1'b0;
            resp_valid  <= g_onehot;
         end else if (finish_err) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= g_onehot;
         end
      end
   end

endmodule
